// File: rtl/adler32_ctrl_if.sv
// Upstream word stream into the Adler-32 sequencer: ready/valid with last-word
// byte count. Signal names carry the controller-side direction.
interface adler32_ctrl_if;
   logic        s_val_i;
   logic        s_rdy_o;
   logic [31:0] s_dat_i;
   logic        s_lst_i;
   logic [1:0]  s_nbyt_i;

   modport master (
      output s_val_i, s_dat_i, s_lst_i, s_nbyt_i,
      input  s_rdy_o
   );

   modport slave (
      input  s_val_i, s_dat_i, s_lst_i, s_nbyt_i,
      output s_rdy_o
   );
endinterface

// File: rtl/adler32_ctrl.sv
// Sequencer for the four-cycle-per-word adler32 engine: paces stream words into
// the engine, then fixes the checksum for zero bytes padded into the last word.
module adler32_ctrl (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic                 start_i,
   adler32_ctrl_if.slave        s_if,
   output logic                 eng_start_o,
   output logic                 eng_val_o,
   output logic [31:0]          eng_dat_o,
   output logic                 eng_lst_o,
   input  logic [31:0]          eng_dat_i,
   output logic                 busy_o,
   output logic                 done_o,
   output logic [31:0]          adler_o
);

   localparam int unsigned DataWd     = 32;
   localparam int unsigned CycPerWord = 4;
   // HOLD spans the engine cycles after ISSUE; counter runs 0..HoldLast.
   localparam logic [1:0]  HoldLast   = 2'(CycPerWord - 2);
   localparam logic [17:0] AdlerMod   = 18'd65521;

   typedef enum logic [2:0] {StIdle, StArm, StFeed, StIssue, StHold, StFin, StCorr} state_e;

   state_e              state_q;
   logic [1:0]          hold_cnt_q;
   logic [1:0]          nbyt_q;
   logic [15:0]         s1_q, s2_q;
   logic                s_rdy_q, eng_start_q, eng_val_q, eng_lst_q, busy_q, done_q;
   logic [DataWd-1:0]   eng_dat_q, adler_q;

   logic                accept;
   logic [DataWd-1:0]   dat_masked;
   logic [1:0]          pad_k;
   logic [17:0]         s1_neg;
   logic [17:0]         corr_sum;

   assign accept = s_rdy_q & s_if.s_val_i;

   // Zero the unused byte lanes of a partial last word (big-endian lanes).
   always_comb begin
      dat_masked = s_if.s_dat_i;
      if (s_if.s_lst_i) begin
         case (s_if.s_nbyt_i)
            2'd1:    dat_masked = {s_if.s_dat_i[31:24], 24'd0};
            2'd2:    dat_masked = {s_if.s_dat_i[31:16], 16'd0};
            2'd3:    dat_masked = {s_if.s_dat_i[31:8], 8'd0};
            default: dat_masked = s_if.s_dat_i;
         endcase
      end
   end

   // Each padded zero byte added s1 to s2; remove k*s1 modulo 65521.
   always_comb begin
      pad_k    = 2'd0 - nbyt_q;  // 4-n mod 4, so n=0 gives k=0
      s1_neg   = AdlerMod - {2'b00, s1_q};
      corr_sum = {2'b00, s2_q} + ({16'd0, pad_k} * s1_neg);
      for (int i = 0; i < 3; i++) begin
         if (corr_sum >= AdlerMod) corr_sum = corr_sum - AdlerMod;
      end
   end

   // Sequencer FSM; every output is a register updated alongside the state.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q     <= StIdle;
         hold_cnt_q  <= 2'd0;
         nbyt_q      <= 2'd0;
         s1_q        <= 16'd0;
         s2_q        <= 16'd0;
         s_rdy_q     <= 1'b0;
         eng_start_q <= 1'b0;
         eng_val_q   <= 1'b0;
         eng_lst_q   <= 1'b0;
         eng_dat_q   <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         adler_q     <= '0;
      end else begin
         eng_start_q <= 1'b0;
         eng_val_q   <= 1'b0;
         s_rdy_q     <= 1'b0;
         done_q      <= 1'b0;
         // Ready is only ever high in FEED or at the last HOLD cycle of a non-last word.
         if (accept) begin
            eng_dat_q <= dat_masked;
            eng_lst_q <= s_if.s_lst_i;
            nbyt_q    <= s_if.s_nbyt_i;
         end
         unique case (state_q)
            StIdle: begin
               if (start_i) begin
                  eng_start_q <= 1'b1;
                  busy_q      <= 1'b1;
                  state_q     <= StArm;
               end
            end
            StArm: begin
               s_rdy_q <= 1'b1;
               state_q <= StFeed;
            end
            StFeed: begin
               if (accept) begin
                  eng_val_q <= 1'b1;
                  state_q   <= StIssue;
               end else begin
                  s_rdy_q <= 1'b1;
               end
            end
            StIssue: begin
               hold_cnt_q <= 2'd0;
               state_q    <= StHold;
            end
            StHold: begin
               if (hold_cnt_q == HoldLast) begin
                  if (eng_lst_q) begin
                     state_q <= StFin;
                  end else if (accept) begin
                     eng_val_q <= 1'b1;
                     state_q   <= StIssue;
                  end else begin
                     s_rdy_q <= 1'b1;
                     state_q <= StFeed;
                  end
               end else begin
                  hold_cnt_q <= hold_cnt_q + 2'd1;
                  if ((hold_cnt_q == HoldLast - 2'd1) && !eng_lst_q) s_rdy_q <= 1'b1;
               end
            end
            StFin: begin
               s2_q    <= eng_dat_i[31:16];
               s1_q    <= eng_dat_i[15:0];
               state_q <= StCorr;
            end
            StCorr: begin
               adler_q <= {corr_sum[15:0], s1_q};
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign s_if.s_rdy_o = s_rdy_q;
   assign eng_start_o  = eng_start_q;
   assign eng_val_o    = eng_val_q;
   assign eng_dat_o    = eng_dat_q;
   assign eng_lst_o    = eng_lst_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign adler_o      = adler_q;

endmodule

// File: tb/tb_adler32_ctrl.sv
// Directed bench for adler32_ctrl with a behavioural four-byte-per-word engine.
module tb_adler32_ctrl;

   logic        clk;
   logic        rstn;
   logic        start_i;
   logic        eng_start_o, eng_val_o, eng_lst_o, busy_o, done_o;
   logic [31:0] eng_dat_o, eng_dat_i, adler_o;
   logic [31:0] eng_model_q;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] wq[$];

   adler32_ctrl_if s_if ();

   adler32_ctrl dut (
      .clk         (clk),
      .rstn        (rstn),
      .start_i     (start_i),
      .s_if        (s_if),
      .eng_start_o (eng_start_o),
      .eng_val_o   (eng_val_o),
      .eng_dat_o   (eng_dat_o),
      .eng_lst_o   (eng_lst_o),
      .eng_dat_i   (eng_dat_i),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .adler_o     (adler_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] adler_step(input logic [31:0] acc, input logic [31:0] w);
      int unsigned a, b;
      a = {16'd0, acc[15:0]};
      b = {16'd0, acc[31:16]};
      for (int i = 3; i >= 0; i--) begin
         a = (a + {24'd0, w[i*8 +: 8]}) % 65521;
         b = (b + a) % 65521;
      end
      return {b[15:0], a[15:0]};
   endfunction

   // Engine model: restarts on start, folds all four bytes of the word on val.
   always @(posedge clk) begin
      if (!rstn || eng_start_o) eng_model_q <= 32'h0000_0001;
      else if (eng_val_o)       eng_model_q <= adler_step(eng_model_q, eng_dat_o);
   end
   assign eng_dat_i = eng_model_q;

   function automatic logic [31:0] lane_mask(input logic [31:0] w, input logic lst,
                                             input logic [1:0] nb);
      if (!lst || nb == 2'd0) return w;
      if (nb == 2'd1) return w & 32'hFF00_0000;
      if (nb == 2'd2) return w & 32'hFFFF_0000;
      return w & 32'hFFFF_FF00;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // Runs the stream in wq; rst_word >= 0 pulses rstn during HOLD of that word.
   task automatic run_stream(input logic [1:0] nb, input int gap, input bit extra_start,
                             input int rst_word, output logic [31:0] res, output bit seen_done);
      int cyc, idx, gapc, last_acc, prev_acc, first_acc, nacc;
      int starts, val_err, dat_err, rdy_err, busy_err, pace_err, ndone;
      logic [31:0] cur_exp;
      cyc = 0; idx = 0; gapc = 0; last_acc = -100; prev_acc = -100; first_acc = -100;
      nacc = 0; starts = 0; val_err = 0; dat_err = 0; rdy_err = 0; busy_err = 0;
      pace_err = 0; cur_exp = '0; res = '0; seen_done = 1'b0;
      @(posedge clk); #1;
      while (!seen_done && cyc < 300) begin
         start_i = (cyc == 0) || (extra_start && nacc > 0 && cyc == first_acc + 2);
         if (idx < wq.size() && gapc == 0) begin
            s_if.s_val_i  = 1'b1;
            s_if.s_dat_i  = wq[idx];
            s_if.s_lst_i  = (idx == wq.size() - 1);
            s_if.s_nbyt_i = (idx == wq.size() - 1) ? nb : 2'd2;
         end else begin
            s_if.s_val_i  = 1'b0;
            s_if.s_dat_i  = 32'hDEAD_BEEF;
            s_if.s_lst_i  = 1'b0;
            s_if.s_nbyt_i = 2'd0;
         end
         if (rst_word >= 0 && nacc == rst_word + 1 && cyc == last_acc + 2) begin
            rstn = 1'b0;
            s_if.s_val_i = 1'b0;
            @(posedge clk); #1;
            rstn = 1'b1;
            @(negedge clk);
            check_eq("rst_ctl", {26'd0, eng_start_o, eng_val_o, eng_lst_o, busy_o, done_o,
                                 s_if.s_rdy_o}, 32'd0);
            check_eq("rst_edat", eng_dat_o, 32'd0);
            check_eq("rst_adler", adler_o, 32'd0);
            ndone = 0;
            for (int i = 0; i < 30; i++) begin
               @(negedge clk);
               if (done_o) ndone++;
            end
            check_eq("rst_no_done", ndone, 32'd0);
            return;
         end
         @(negedge clk);
         if (eng_start_o) starts++;
         if (eng_val_o !== (cyc == last_acc + 1)) val_err++;
         if (cyc >= last_acc + 1 && cyc <= last_acc + 4 && eng_dat_o !== cur_exp) dat_err++;
         if (s_if.s_rdy_o && (cyc < 2 || (nacc > 0 && (cyc < last_acc + 4 || idx >= wq.size()))))
            rdy_err++;
         if (cyc >= 1 && !done_o && !busy_o) busy_err++;
         if (done_o) begin
            seen_done = 1'b1;
            res = adler_o;
            check_eq("done_lat", 32'(cyc - last_acc), 32'd7);
            check_eq("busy_at_done", {31'd0, busy_o}, 32'd0);
         end
         if (s_if.s_rdy_o && s_if.s_val_i) begin
            prev_acc = last_acc;
            last_acc = cyc;
            if (nacc == 0) first_acc = cyc;
            else if (gap == 0 && cyc - prev_acc != 4) pace_err++;
            cur_exp = lane_mask(s_if.s_dat_i, s_if.s_lst_i, s_if.s_nbyt_i);
            nacc++;
            idx++;
            gapc = gap;
         end else if (gapc > 0) begin
            gapc--;
         end
         @(posedge clk); #1;
         cyc++;
      end
      start_i = 1'b0;
      s_if.s_val_i = 1'b0;
      check_eq("done_seen", {31'd0, seen_done}, 32'd1);
      check_eq("first_acc", 32'(first_acc), 32'd2);
      check_eq("eng_start_cnt", 32'(starts), 32'd1);
      check_eq("eng_val_window", 32'(val_err), 32'd0);
      check_eq("eng_dat_stable", 32'(dat_err), 32'd0);
      check_eq("s_rdy_pattern", 32'(rdy_err), 32'd0);
      check_eq("busy_span", 32'(busy_err), 32'd0);
      check_eq("pace", 32'(pace_err), 32'd0);
   endtask

   logic [31:0] res;
   bit          seen;

   initial begin
      rstn = 1'b0;
      start_i = 1'b0;
      s_if.s_val_i = 1'b0;
      s_if.s_dat_i = '0;
      s_if.s_lst_i = 1'b0;
      s_if.s_nbyt_i = 2'd0;
      repeat (3) @(posedge clk);
      #1 rstn = 1'b1;
      @(negedge clk);
      check_eq("reset_ctl", {26'd0, eng_start_o, eng_val_o, eng_lst_o, busy_o, done_o,
                             s_if.s_rdy_o}, 32'd0);
      check_eq("reset_adler", adler_o, 32'd0);

      wq = '{32'h6162_6300};
      run_stream(2'd3, 0, 1'b0, -1, res, seen);
      check_eq("abc", res, 32'h024D_0127);
      repeat (3) @(negedge clk);
      check_eq("adler_held", adler_o, 32'h024D_0127);
      check_eq("done_pulse", {31'd0, done_o}, 32'd0);

      wq = '{32'h6162_6364};
      run_stream(2'd0, 0, 1'b0, -1, res, seen);
      check_eq("abcd", res, 32'h03D8_018B);

      wq = '{32'h6162_63FF};
      run_stream(2'd3, 0, 1'b0, -1, res, seen);
      check_eq("abc_garbage", res, 32'h024D_0127);

      wq = '{32'h5769_6B69, 32'h7065_6469, 32'h6100_0000};
      run_stream(2'd1, 0, 1'b0, -1, res, seen);
      check_eq("wiki_cont", res, 32'h11E6_0398);

      run_stream(2'd1, 5, 1'b0, -1, res, seen);
      check_eq("wiki_stall", res, 32'h11E6_0398);

      run_stream(2'd1, 0, 1'b1, -1, res, seen);
      check_eq("wiki_xstart", res, 32'h11E6_0398);

      run_stream(2'd1, 0, 1'b0, 1, res, seen);
      check_eq("rst_seen_done", {31'd0, seen}, 32'd0);

      wq = '{32'h6162_6300};
      run_stream(2'd3, 0, 1'b0, -1, res, seen);
      check_eq("abc_after_rst", res, 32'h024D_0127);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/adler32_ctrl.md
# adler32_ctrl

Sequencer in front of the `adler32` engine. It accepts a 32-bit word stream over a ready/valid handshake and issues `start_i` to the engine. It paces the words at the engine's fixed four-cycle-per-word cadence, holding each word stable while the engine consumes it. It then collects the engine's checksum, corrects it for a partial final word, and presents the result with a one-cycle done pulse.

## Interface
- `DATA_WD`, 32: stream and engine data width; fixed, big-endian byte order (byte 0 in `[31:24]`).
- `CYC_PER_WORD`, 4: engine cycles per word; must match the engine; fixed.

Ports:
- `clk`  in  1  sole clock.
- `rstn`  in  1  reset, synchronous, active-low.
  - The same net drives the engine's `rstn`.
- `start_i`  in  1  one-cycle pulse that opens a stream; honoured only in IDLE.
- `s_val_i`  in  1  input word valid.
- `s_rdy_o`  out  1  controller can accept a word.
- `s_dat_i`  in  32  input word.
- `s_lst_i`  in  1  last word of the stream; sampled on accept.
- `s_nbyt_i`  in  2  valid bytes in the last word; 0 means 4; ignored on non-last words.
- `eng_start_o`  out  1  to engine `start_i`.
- `eng_val_o`  out  1  to engine `val_i`.
- `eng_dat_o`  out  32  to engine `dat_i`.
- `eng_lst_o`  out  1  to engine `lst_i`.
- `eng_dat_i`  in  32  from engine `dat_o`, as `{s2,s1}`.
- `busy_o`  out  1  high in any state other than IDLE.
- `done_o`  out  1  one-cycle pulse; `adler_o` is valid from this cycle.
- `adler_o`  out  32  corrected checksum; held until the next `done_o` or reset.

## Operation
- All outputs are registered. Reset value of every output is 0.
- FSM states: IDLE, ARM, FEED, ISSUE, HOLD, FIN, CORR.
- IDLE:
  - `start_i` causes `eng_start_o` = 1 for exactly the next cycle, and the FSM goes to ARM.
  - `start_i` in any other state is ignored.
- ARM: the engine is entering its active state. Go to FEED.
- FEED: `s_rdy_o` = 1. On `s_val_i`, the controller:
  - latches the word into `eng_dat_o`;
  - latches `s_lst_i` into `eng_lst_o` and latches `s_nbyt_i`;
  - goes to ISSUE.
- Byte masking on a last word with `s_nbyt_i`=n≠0: bytes n..3 of `eng_dat_o` are forced to 0 before latching.
- ISSUE: `eng_val_o` = 1 for this single cycle (the engine's active cycle). Go to HOLD with hold counter = 0.
- HOLD (3 cycles, counter 0..2):
  - `eng_val_o` = 0; `eng_dat_o` and `eng_lst_o` held.
  - At counter 2 with the current word not last: `s_rdy_o` = 1.
    - Accept → ISSUE (back-to-back, no bubble).
    - No accept → FEED.
  - At counter 2 with the current word last → FIN.
- FIN: the engine result is now stable. Latch `eng_dat_i` into internal s2/s1. Go to CORR.
- CORR, zero-pad correction with k = 4 − n (k = 0 when n = 0):
  - s2c = (s2 + k·(65521 − s1)) mod 65521.
  - The intermediate sum is 18 bits and always < 4·65521.
  - The reduction is up to three conditional subtractions of 65521, single cycle.
  - s1 is unchanged.
  - Register `adler_o` = {s2c, s1} and `done_o` = 1, then go to IDLE.
- A stream has at least one word. Empty streams are not supported.

## Timing
- Throughput: one word per 4 cycles under continuous `s_val_i`. `s_rdy_o` pattern is 1,0,0,0 repeating after the first accept.
- First accept is possible 2 cycles after `start_i`: `start_i` at t, ARM at t+1, FEED at t+2.
- `eng_dat_o` is stable for the 4 cycles ISSUE..HOLD2 of each word.
- Latency: with the last word accepted at cycle t:
  - ISSUE at t+1, HOLD at t+2..t+4, FIN at t+5, CORR at t+6.
  - `done_o` and `adler_o` are updated at t+7. `busy_o` falls at t+7.
- Reset mid-operation: `rstn` low at any clock edge returns the FSM to IDLE, clears all outputs and drops the stream. The engine is reset by the same net. The first `start_i` after reset release is honoured.
- `start_i` coincident with the `done_o` cycle: the FSM is already in IDLE, so the start is honoured.

## Test plan
- "abc": `start_i`, then one word 0x61626300 with `lst`=1 and `nbyt`=3 → `done_o` 7 cycles after accept, `adler_o`=0x024D0127.
- "abcd": 0x61626364 with `lst`=1 and `nbyt`=0 → `adler_o`=0x03D8018B. `s_dat_i` garbage in unused lanes (0x616263FF, `nbyt`=3) → 0x024D0127.
- "Wikipedia": 0x57696B69, 0x70656469, 0x61000000 with `nbyt`=1 and `s_val_i` held high → `s_rdy_o` high every 4th cycle, `eng_dat_o` stable 4 cycles per word, `adler_o`=0x11E60398.
- Upstream stalls: same "Wikipedia" stream with 5-cycle gaps between words → identical result. The engine's `val_i` is never high outside ISSUE.
- `start_i` pulsed during HOLD → ignored, with no extra `eng_start_o` and an unchanged result.
- `rstn` low for 1 cycle during HOLD of word 2 → all outputs 0 the next cycle and no `done_o`. A following "abc" stream gives 0x024D0127.
